// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding,
// default widths and the control-vector bit ordering used by the pipeline top.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } pipe_state_e;

  localparam int DEF_WAIT_W = 8;
  localparam int DEF_CNT_W  = 32;

  // Bit positions inside the control vector handed to the pipeline top.
  localparam int OUT_PC_WRITE    = 0;
  localparam int OUT_IF_ID_WRITE = 1;
  localparam int OUT_IF_ID_FLUSH = 2;
  localparam int OUT_ID_EX_BUBBLE = 3;
  localparam int OUT_FREEZE      = 4;
  localparam int OUT_W           = 5;

  // Canonical control patterns, {freeze, bubble, flush, if_id_write, pc_write}.
  localparam logic [OUT_W-1:0] CTRL_RUN    = 5'b00011;
  localparam logic [OUT_W-1:0] CTRL_FLUSH  = 5'b00111;
  localparam logic [OUT_W-1:0] CTRL_BUBBLE = 5'b01000;
  localparam logic [OUT_W-1:0] CTRL_FREEZE = 5'b10000;

endpackage

// File: rtl/stall_sat_cnt.sv
// Counter with clear/increment and a saturate-or-wrap select. A clear with a
// simultaneous increment loads 1, so the first counted cycle is never lost.
module stall_sat_cnt #(
  parameter int W   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX_V = '1;

  logic [W-1:0] cnt_q, cnt_d;

  // Next-count selection: clear, then increment with saturate or wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = W'(inc_i);
    end else if (inc_i) begin
      if (SAT && (cnt_q == MAX_V)) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Arbitrates
// memory-busy, branch-taken and load-use hazards into PC / IF/ID / ID/EX
// controls with zero latency, remembers a redirect seen during a memory
// freeze, and flags memory waits that never end.
// Optional build macro PIPE_STALL_PERF_CNT_EN adds the performance counters;
// without it the *_cnt_o ports read 0.
//
// Interface semantics: there is no valid/ready handshake. Every hazard input
// is a level sampled in the cycle it is raised; the controls it causes are
// driven combinationally in that same cycle, and all state advances on the
// rising edge of clk_i.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_MEM_WAIT = 255,
  parameter int WAIT_W       = DEF_WAIT_W,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             mem_stall_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             freeze_o,
  output logic             state_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] load_use_cnt_o,
  output logic [CNT_W-1:0] mem_stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // A MEM_WAIT cycle whose incoming count is MAX_MEM_WAIT-1 is freeze cycle
  // number MAX_MEM_WAIT; the saturated count always satisfies the compare.
  localparam logic [WAIT_W-1:0] MAX_M1 = WAIT_W'(MAX_MEM_WAIT - 1);

  pipe_state_e       state_q, state_d;
  logic              flush_pend_q, flush_pend_d;
  logic              timeout_q, timeout_d;
  logic [OUT_W-1:0]  ctrl;
  logic              wait_clr, wait_inc;
  logic [WAIT_W-1:0] wait_cnt;

  // Priority decode (memory > flush > load-use) and next-state selection.
  always_comb begin
    ctrl         = CTRL_RUN;
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    timeout_d    = timeout_q;
    wait_clr     = 1'b1;
    wait_inc     = 1'b0;
    if (!rst_i) begin
      ctrl = CTRL_RUN;
    end else if (mem_stall_i) begin
      ctrl     = CTRL_FREEZE;
      state_d  = ST_MEM_WAIT;
      wait_inc = 1'b1;
      if (state_q == ST_RUN) begin
        // First freeze cycle: count restarts at 1, any old redirect is moot.
        flush_pend_d = branch_taken_i;
        wait_clr     = 1'b1;
        if (MAX_MEM_WAIT == 1) begin
          timeout_d = 1'b1;
        end
      end else begin
        flush_pend_d = flush_pend_q | branch_taken_i;
        wait_clr     = 1'b0;
        if (wait_cnt >= MAX_M1) begin
          timeout_d = 1'b1;
        end
      end
    end else begin
      state_d      = ST_RUN;
      flush_pend_d = 1'b0;
      if (branch_taken_i || flush_pend_q) begin
        // The flushed instruction is the load-use consumer, so load_use_i
        // needs no bubble here.
        ctrl = CTRL_FLUSH;
      end else if (load_use_i) begin
        ctrl = CTRL_BUBBLE;
      end
    end
  end

  // State, pending redirect and sticky timeout registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_RUN;
      flush_pend_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      timeout_q    <= timeout_d;
    end
  end

  stall_sat_cnt #(
    .W   (WAIT_W),
    .SAT (1'b1)
  ) u_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (wait_clr),
    .inc_i (wait_inc),
    .cnt_o (wait_cnt)
  );

`ifdef PIPE_STALL_PERF_CNT_EN
  stall_sat_cnt #(
    .W   (CNT_W),
    .SAT (1'b0)
  ) u_load_use_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (ctrl[OUT_ID_EX_BUBBLE]),
    .cnt_o (load_use_cnt_o)
  );

  stall_sat_cnt #(
    .W   (CNT_W),
    .SAT (1'b0)
  ) u_mem_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (ctrl[OUT_FREEZE]),
    .cnt_o (mem_stall_cnt_o)
  );

  stall_sat_cnt #(
    .W   (CNT_W),
    .SAT (1'b0)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (ctrl[OUT_IF_ID_FLUSH]),
    .cnt_o (flush_cnt_o)
  );
`else
  assign load_use_cnt_o  = '0;
  assign mem_stall_cnt_o = '0;
  assign flush_cnt_o     = '0;
`endif

  assign pc_write_o     = ctrl[OUT_PC_WRITE];
  assign if_id_write_o  = ctrl[OUT_IF_ID_WRITE];
  assign if_id_flush_o  = ctrl[OUT_IF_ID_FLUSH];
  assign id_ex_bubble_o = ctrl[OUT_ID_EX_BUBBLE];
  assign freeze_o       = ctrl[OUT_FREEZE];
  assign state_o        = (state_q == ST_MEM_WAIT);
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed hazard scenarios followed
// by randomized traffic, scored against a cycle-level reference model.
module tb_pipe_stall_ctrl;

  localparam int MAX_MEM_WAIT = 5;
  localparam int WAIT_W       = 3;
  localparam int CNT_W        = 4;
  localparam int EXP_W        = 3 * CNT_W + 7;

`ifdef PIPE_STALL_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic load_use_i = 1'b0;
  logic branch_taken_i = 1'b0;
  logic mem_stall_i = 1'b0;
  logic pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, freeze_o;
  logic state_o, timeout_o;
  logic [CNT_W-1:0] load_use_cnt_o, mem_stall_cnt_o, flush_cnt_o;

  always #5 clk_i = ~clk_i;

  pipe_stall_ctrl #(
    .MAX_MEM_WAIT (MAX_MEM_WAIT),
    .WAIT_W       (WAIT_W),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .load_use_i      (load_use_i),
    .branch_taken_i  (branch_taken_i),
    .mem_stall_i     (mem_stall_i),
    .pc_write_o      (pc_write_o),
    .if_id_write_o   (if_id_write_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_bubble_o  (id_ex_bubble_o),
    .freeze_o        (freeze_o),
    .state_o         (state_o),
    .timeout_o       (timeout_o),
    .load_use_cnt_o  (load_use_cnt_o),
    .mem_stall_cnt_o (mem_stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  // ---------------- reference model ----------------
  // Stall episode described by its length so far; a redirect seen in an
  // episode is remembered until the episode ends.
  int m_len = 0;
  bit m_pend = 0;
  bit m_to = 0;
  int m_lu = 0, m_ms = 0, m_fl = 0;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [EXP_W-1:0] actual_vec();
    return {load_use_cnt_o, mem_stall_cnt_o, flush_cnt_o, timeout_o, state_o,
            freeze_o, id_ex_bubble_o, if_id_flush_o, if_id_write_o, pc_write_o};
  endfunction

  task automatic model_reset();
    m_len = 0; m_pend = 0; m_to = 0; m_lu = 0; m_ms = 0; m_fl = 0;
  endtask

  // Expected outputs for the current cycle, then advance the model one edge.
  task automatic model_cycle(input logic rst, input logic lu, input logic br, input logic ms);
    bit pc, ifw, fl, bub, frz, st;
    logic [CNT_W-1:0] c_lu, c_ms, c_fl;
    pc = 1; ifw = 1; fl = 0; bub = 0; frz = 0;
    if (!rst) model_reset();
    st   = (m_len > 0);
    c_lu = CNT_EN ? CNT_W'(m_lu) : '0;
    c_ms = CNT_EN ? CNT_W'(m_ms) : '0;
    c_fl = CNT_EN ? CNT_W'(m_fl) : '0;
    exp_q.push_back({c_lu, c_ms, c_fl, m_to, st, 5'b00000});
    if (rst) begin
      if (ms) begin
        frz = 1; pc = 0; ifw = 0;
        m_pend = ((m_len > 0) && m_pend) || br;
        m_len++;
        if (m_len >= MAX_MEM_WAIT) m_to = 1;
      end else begin
        m_len = 0;
        if (br || m_pend) fl = 1;
        else if (lu) begin bub = 1; pc = 0; ifw = 0; end
        m_pend = 0;
      end
      m_lu += int'(bub); m_ms += int'(frz); m_fl += int'(fl);
    end
    exp_q[$][4:0] = {frz, bub, fl, ifw, pc};
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic lu, input logic br, input logic ms);
    @(posedge clk_i);
    #1;
    rst_i = rst; load_use_i = lu; branch_taken_i = br; mem_stall_i = ms;
    model_cycle(rst, lu, br, ms);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_i) begin
    logic [EXP_W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = actual_vec();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t actual={cnt lu/ms/fl=%0d/%0d/%0d to=%b st=%b frz=%b bub=%b fl=%b ifw=%b pc=%b} required={cnt lu/ms/fl=%0d/%0d/%0d to=%b st=%b frz=%b bub=%b fl=%b ifw=%b pc=%b}",
                 $time, a[EXP_W-1 -: CNT_W], a[2*CNT_W+6 : CNT_W+7], a[CNT_W+6:7], a[6], a[5], a[4], a[3], a[2], a[1], a[0],
                 e[EXP_W-1 -: CNT_W], e[2*CNT_W+6 : CNT_W+7], e[CNT_W+6:7], e[6], e[5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic rs, lu, br, ms;
    logic [EXP_W-1:0] rst_vec;
    rst_vec = '0;
    rst_vec[1:0] = 2'b11;

    // Reset with hazards active: inputs must be ignored.
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    step(0, 0, 1, 0);
    idle(2);

    // Single load-use cycle, then normal.
    step(1, 1, 0, 0);
    idle(2);

    // Branch and load-use together: flush wins, no bubble.
    step(1, 1, 1, 0);
    idle(2);

    // Held load-use: one bubble per cycle.
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    idle(1);

    // 4-cycle freeze with a branch pulse in cycle 2; flush on release.
    step(1, 0, 0, 1); step(1, 0, 1, 1); step(1, 0, 0, 1); step(1, 0, 0, 1);
    step(1, 1, 0, 0);
    idle(2);

    // Freeze release with load-use and no redirect: bubble.
    step(1, 0, 0, 1); step(1, 0, 0, 0);
    step(1, 0, 0, 1); step(1, 1, 0, 0);
    // Branch arriving on the release cycle itself.
    step(1, 0, 0, 1); step(1, 1, 1, 0);
    idle(1);

    // Stall of exactly MAX_MEM_WAIT-1 cycles: no timeout.
    for (int i = 0; i < MAX_MEM_WAIT - 1; i++) step(1, 0, 0, 1);
    idle(2);

    // 10-cycle stall: timeout rises after cycle 5 and stays sticky.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1);
    idle(3);
    // Long stall saturating the wait count.
    for (int i = 0; i < 20; i++) step(1, 0, i == 3, 1);
    idle(2);

    // Asynchronous reset mid-freeze with a pending redirect.
    step(1, 0, 0, 1);
    step(1, 0, 1, 1);
    @(posedge clk_i);
    #1;
    mem_stall_i = 1; branch_taken_i = 0;
    #2;
    rst_i = 0;
    #1;
    n_checks++;
    if (actual_vec() !== rst_vec) begin
      n_fail++;
      $display("FAIL async_reset actual=%h required=%h", actual_vec(), rst_vec);
    end
    model_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    idle(2);

    // Randomized traffic with occasional resets.
    ms = 0;
    for (int i = 0; i < 2000; i++) begin
      rs = ($urandom_range(0, 149) != 0);
      lu = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 4) == 0);
      if (ms) ms = ($urandom_range(0, 9) < 8);
      else    ms = ($urandom_range(0, 9) < 2);
      step(rs, lu, br, ms);
    end
    idle(3);

    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
